// File: rtl/bcd_lap_counter.sv
// bcd_lap_counter
//   N-digit BCD up/down time counter with per-digit rollover limits, one-cycle
//   carry/borrow ripple, wrap-or-saturate ends, sticky overflow and a lap
//   snapshot register that freezes the displayed value while counting runs on.
// Ports
//   clk           rising-edge clock
//   reset         asynchronous reset, active low
//   clear         synchronous clear of count, lap and overflow state
//   inc / dec     one tick up / down (both together cancel)
//   lap           capture the pre-tick count and freeze the display on it
//   lap_release   return display to live count (lap wins if both set)
//   digits        live count, registered, digit 0 in [3:0]
//   lap_digits    last captured count, registered
//   shown_digits  lap_active ? lap_digits : digits
//   lap_active    display frozen on lap_digits
//   at_max        digits == ROLLOVER
//   at_zero       digits == 0
//   overflow      sticky, set on any wrap past max or below zero

// Per-digit step values. Carry/borrow chaining lives in the parent so the
// whole ripple is evaluated in one combinational pass.
module bcd_lap_digit (
    input  logic [3:0] cur,
    input  logic [3:0] lim,
    output logic [3:0] inc_val,
    output logic [3:0] dec_val,
    output logic       at_lim,
    output logic       at_zero
);
    // A digit above its limit only appears after a fault; it rolls to 0
    // with carry exactly like a digit sitting at its limit.
    assign at_lim  = (cur >= lim);
    assign at_zero = (cur == 4'd0);
    assign inc_val = at_lim  ? 4'd0 : cur + 4'd1;
    assign dec_val = at_zero ? lim  : cur - 4'd1;
endmodule

module bcd_lap_counter #(
    parameter int                   NDIGITS  = 5,
    parameter logic [4*NDIGITS-1:0] ROLLOVER = 20'h59599,
    parameter bit                   WRAP     = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   inc,
    input  logic                   dec,
    input  logic                   lap,
    input  logic                   lap_release,
    output logic [4*NDIGITS-1:0]   digits,
    output logic [4*NDIGITS-1:0]   lap_digits,
    output logic [4*NDIGITS-1:0]   shown_digits,
    output logic                   lap_active,
    output logic                   at_max,
    output logic                   at_zero,
    output logic                   overflow
);
    logic [NDIGITS-1:0][3:0] cnt_q, lap_q, cnt_nxt, lim, inc_v, dec_v;
    logic [NDIGITS-1:0]      dig_lim, dig_zero;
    logic                    up_c, dn_c, wrap_hit;
    logic                    lap_act_q, ovf_q;

    assign lim = ROLLOVER;

    generate
        for (genvar g = 0; g < NDIGITS; g++) begin : g_dig
            bcd_lap_digit u_dig (
                .cur     (cnt_q[g]),
                .lim     (lim[g]),
                .inc_val (inc_v[g]),
                .dec_val (dec_v[g]),
                .at_lim  (dig_lim[g]),
                .at_zero (dig_zero[g])
            );
        end
    endgenerate

    // Ripple: a digit steps only while every lower digit rolled over.
    // Carry/borrow surviving past the top digit means we were at an end.
    always_comb begin
        cnt_nxt  = cnt_q;
        up_c     = inc & ~dec;
        dn_c     = dec & ~inc;
        for (int k = 0; k < NDIGITS; k++) begin
            if (up_c)
                cnt_nxt[k] = inc_v[k];
            else if (dn_c)
                cnt_nxt[k] = dec_v[k];
            up_c = up_c & dig_lim[k];
            dn_c = dn_c & dig_zero[k];
        end
        wrap_hit = up_c | dn_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            lap_q     <= '0;
            lap_act_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (clear) begin
            cnt_q     <= '0;
            lap_q     <= '0;
            lap_act_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            // At an end the rippled value is already the wrapped value;
            // saturating mode simply discards it.
            if (!wrap_hit) begin
                cnt_q <= cnt_nxt;
            end else if (WRAP) begin
                cnt_q <= cnt_nxt;
                ovf_q <= 1'b1;
            end
            // Snapshot is the count before this cycle's tick.
            if (lap) begin
                lap_q     <= cnt_q;
                lap_act_q <= 1'b1;
            end else if (lap_release) begin
                lap_act_q <= 1'b0;
            end
        end
    end

    assign digits       = cnt_q;
    assign lap_digits   = lap_q;
    assign lap_active   = lap_act_q;
    assign overflow     = ovf_q;
    assign shown_digits = lap_act_q ? lap_q : cnt_q;
    assign at_max       = (cnt_q == lim);
    assign at_zero      = (cnt_q == '0);
endmodule
